// File: rtl/bcd_timer.sv
// Synchronous mm:ss BCD timer: countdown or count-up, saturating edits, and a
// blinking display enable once the count has ended.
module bcd_timer #(
  parameter int CLK_DIV    = 25_000_000,
  parameter int BLINK_DIV  = 12_500_000,
  parameter int MIN_DIGITS = 2
) (
  input  logic                    MCLK,
  input  logic                    RST,
  input  logic                    START_STOP,
  input  logic                    CLEAR,
  input  logic                    ADD_SEC,
  input  logic                    ADD_MIN,
  input  logic                    MODE,
  output logic [7:0]              SEC_BCD,
  output logic [4*MIN_DIGITS-1:0] MIN_BCD,
  output logic                    RUNNING,
  output logic                    ENDED,
  output logic                    BLINK,
  output logic                    TICK
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int TW = MW + 8;
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   val_q, val_d;
  logic            mode_q, mode_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blk_cnt_q, blk_cnt_d;
  logic            blink_q, blink_d;
  logic            ss_prev_q, clr_prev_q, as_prev_q, am_prev_q;
  logic            ss_edge, clr_edge, as_edge, am_edge;
  logic            tick;

  function automatic logic min_is_max(input logic [MW-1:0] m);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++)
      if (m[4*i +: 4] != 4'd9) r = 1'b0;
    return r;
  endfunction

  function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          c;
    r = m;
    c = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          b;
    r = m;
    b = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic time_is_max(input logic [TW-1:0] t);
    return min_is_max(t[TW-1:8]) && (t[7:0] == 8'h59);
  endfunction

  // Increment saturates at all-9s:59; decrement stops at 00:00.
  function automatic logic [TW-1:0] time_inc(input logic [TW-1:0] t);
    logic [MW-1:0] m;
    logic [3:0]    st, su;
    if (time_is_max(t)) return t;
    m  = t[TW-1:8];
    st = t[7:4];
    su = t[3:0];
    if (su != 4'd9) su = su + 4'd1;
    else begin
      su = 4'd0;
      if (st != 4'd5) st = st + 4'd1;
      else begin
        st = 4'd0;
        m  = min_inc(m);
      end
    end
    return {m, st, su};
  endfunction

  function automatic logic [TW-1:0] time_dec(input logic [TW-1:0] t);
    logic [MW-1:0] m;
    logic [3:0]    st, su;
    if (t == '0) return t;
    m  = t[TW-1:8];
    st = t[7:4];
    su = t[3:0];
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        m  = min_dec(m);
      end
    end
    return {m, st, su};
  endfunction

  assign ss_edge  = START_STOP & ~ss_prev_q;
  assign clr_edge = CLEAR      & ~clr_prev_q;
  assign as_edge  = ADD_SEC    & ~as_prev_q;
  assign am_edge  = ADD_MIN    & ~am_prev_q;
  assign tick     = (state_q == S_RUN) && (presc_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (clr_edge) val_d = '0;
        else if (ss_edge) begin
          if (MODE || (val_q != '0)) begin
            mode_d  = MODE;
            state_d = S_RUN;
          end
        end else if (am_edge) begin
          if (!min_is_max(val_q[TW-1:8])) val_d = {min_inc(val_q[TW-1:8]), val_q[7:0]};
        end else if (as_edge) val_d = time_inc(val_q);
      end
      S_RUN: begin
        if (ss_edge) state_d = S_IDLE;
        else if (tick) begin
          if (!mode_q) begin
            val_d = time_dec(val_q);
            if (val_d == '0) state_d = S_DONE;
          end else if (time_is_max(val_q)) state_d = S_DONE;
          else val_d = time_inc(val_q);
        end
      end
      S_DONE: begin
        if (clr_edge) begin
          val_d   = '0;
          state_d = S_IDLE;
        end else if (ss_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler and blink counter only advance while staying in their state.
  always_comb begin
    presc_d   = '0;
    blk_cnt_d = '0;
    blink_d   = 1'b1;
    if ((state_q == S_RUN) && (state_d == S_RUN))
      presc_d = tick ? '0 : presc_q + PW'(1);
    if ((state_q == S_DONE) && (state_d == S_DONE)) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BW'(1);
        blink_d   = blink_q;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      val_q      <= '0;
      mode_q     <= 1'b0;
      presc_q    <= '0;
      blk_cnt_q  <= '0;
      blink_q    <= 1'b1;
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
      as_prev_q  <= 1'b1;
      am_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      blk_cnt_q  <= blk_cnt_d;
      blink_q    <= blink_d;
      ss_prev_q  <= START_STOP;
      clr_prev_q <= CLEAR;
      as_prev_q  <= ADD_SEC;
      am_prev_q  <= ADD_MIN;
    end
  end

  assign SEC_BCD = val_q[7:0];
  assign MIN_BCD = val_q[TW-1:8];
  assign RUNNING = (state_q == S_RUN);
  assign ENDED   = (state_q == S_DONE);
  assign BLINK   = blink_q;
  assign TICK    = tick;

endmodule

// File: tb/tb_bcd_timer.sv
// Scoreboard bench for bcd_timer: stimulus queues expected output snapshots,
// a monitor pops and compares them at the following falling edge.
module tb_bcd_timer;

  logic       clk = 1'b0;
  logic       rst, ss, clr, as, am, mode;
  logic [7:0] sec_o, min_o;
  logic       run_o, end_o, blink_o, tick_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [7:0] sec;
    logic [7:0] min;
    logic       run;
    logic       ended;
    logic       blink;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];

  bcd_timer #(.CLK_DIV(10), .BLINK_DIV(4), .MIN_DIGITS(2)) dut (
    .MCLK(clk), .RST(rst), .START_STOP(ss), .CLEAR(clr), .ADD_SEC(as),
    .ADD_MIN(am), .MODE(mode), .SEC_BCD(sec_o), .MIN_BCD(min_o),
    .RUNNING(run_o), .ENDED(end_o), .BLINK(blink_o), .TICK(tick_o)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (sec_o !== e.sec || min_o !== e.min || run_o !== e.run ||
          end_o !== e.ended || blink_o !== e.blink || tick_o !== e.tick) begin
        failures++;
        $display("FAIL %s: got min=%h sec=%h run=%b end=%b blink=%b tick=%b, want min=%h sec=%h run=%b end=%b blink=%b tick=%b",
                 e.name, min_o, sec_o, run_o, end_o, blink_o, tick_o,
                 e.min, e.sec, e.run, e.ended, e.blink, e.tick);
      end
    end
  end

  task automatic push_exp(input string n, input logic [7:0] s, input logic [7:0] m,
                          input logic r, input logic d, input logic b, input logic t);
    exp_t e;
    e.name = n; e.sec = s; e.min = m; e.run = r; e.ended = d; e.blink = b; e.tick = t;
    exp_q.push_back(e);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // m = {START_STOP, CLEAR, ADD_MIN, ADD_SEC}; high for one edge, low for one edge
  task automatic press(input logic [3:0] m);
    {ss, clr, am, as} = m;
    tick_n(1);
    {ss, clr, am, as} = 4'b0;
    tick_n(1);
  endtask

  localparam logic [3:0] B_SS = 4'b1000, B_CLR = 4'b0100, B_AM = 4'b0010, B_AS = 4'b0001;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ss = 1'b0; clr = 1'b0; as = 1'b0; am = 1'b0; mode = 1'b0;
    tick_n(2);
    push_exp("reset", 8'h00, 8'h00, 0, 0, 1, 0);
    rst = 1'b0;
    tick_n(1);

    // countdown from 00:02
    press(B_AS); press(B_AS);
    push_exp("add_sec2", 8'h02, 8'h00, 0, 0, 1, 0);
    ss = 1'b1; tick_n(1); ss = 1'b0;
    push_exp("start_run", 8'h02, 8'h00, 1, 0, 1, 0);
    tick_n(8);  push_exp("pre_tick",   8'h02, 8'h00, 1, 0, 1, 0);
    tick_n(1);  push_exp("tick_hi",    8'h02, 8'h00, 1, 0, 1, 1);
    tick_n(1);  push_exp("dec1",       8'h01, 8'h00, 1, 0, 1, 0);
    tick_n(10); push_exp("done",       8'h00, 8'h00, 0, 1, 1, 0);
    tick_n(3);  push_exp("blink_e23",  8'h00, 8'h00, 0, 1, 1, 0);
    tick_n(1);  push_exp("blink_e24",  8'h00, 8'h00, 0, 1, 0, 0);
    tick_n(3);  push_exp("blink_e27",  8'h00, 8'h00, 0, 1, 0, 0);
    tick_n(1);  push_exp("blink_e28",  8'h00, 8'h00, 0, 1, 1, 0);
    press(B_CLR);
    push_exp("done_clear", 8'h00, 8'h00, 0, 0, 1, 0);

    // carry and saturation
    repeat (60) press(B_AS);
    push_exp("carry_60", 8'h00, 8'h01, 0, 0, 1, 0);
    repeat (98) press(B_AM);
    push_exp("min_99", 8'h00, 8'h99, 0, 0, 1, 0);
    press(B_AM);
    push_exp("min_sat", 8'h00, 8'h99, 0, 0, 1, 0);
    repeat (58) press(B_AS);
    push_exp("preset_9958", 8'h58, 8'h99, 0, 0, 1, 0);

    // count-up overflow
    mode = 1'b1; ss = 1'b1; tick_n(1); ss = 1'b0; mode = 1'b0;
    push_exp("up_run", 8'h58, 8'h99, 1, 0, 1, 0);
    tick_n(10); push_exp("up_tick1", 8'h59, 8'h99, 1, 0, 1, 0);
    tick_n(10); push_exp("up_done",  8'h59, 8'h99, 0, 1, 1, 0);
    press(B_SS); push_exp("done_ss_keep", 8'h59, 8'h99, 0, 0, 1, 0);
    press(B_AS); push_exp("sec_sat",      8'h59, 8'h99, 0, 0, 1, 0);
    press(B_AM); push_exp("min_sat2",     8'h59, 8'h99, 0, 0, 1, 0);

    // zero start and same-cycle priority
    press(B_CLR); push_exp("clear", 8'h00, 8'h00, 0, 0, 1, 0);
    press(B_SS);  push_exp("zero_start", 8'h00, 8'h00, 0, 0, 1, 0);
    press(B_AS);  push_exp("one_sec", 8'h01, 8'h00, 0, 0, 1, 0);
    press(B_SS | B_CLR); push_exp("clr_beats_ss", 8'h00, 8'h00, 0, 0, 1, 0);

    // pause and resume from 01:00
    press(B_AM); push_exp("one_min", 8'h00, 8'h01, 0, 0, 1, 0);
    ss = 1'b1; tick_n(1); ss = 1'b0; tick_n(1);
    tick_n(23);  push_exp("before_pause", 8'h58, 8'h00, 1, 0, 1, 0);
    press(B_SS); push_exp("paused",       8'h58, 8'h00, 0, 0, 1, 0);
    press(B_AS); push_exp("paused_add",   8'h59, 8'h00, 0, 0, 1, 0);
    ss = 1'b1; tick_n(1); ss = 1'b0;
    tick_n(8); push_exp("resume_pre",  8'h59, 8'h00, 1, 0, 1, 0);
    tick_n(1); push_exp("resume_tick", 8'h59, 8'h00, 1, 0, 1, 1);
    tick_n(1); push_exp("resume_dec",  8'h58, 8'h00, 1, 0, 1, 0);

    // guards in RUN
    press(B_AS);  push_exp("run_add_ign",  8'h58, 8'h00, 1, 0, 1, 0);
    press(B_CLR); push_exp("run_clr_ign",  8'h58, 8'h00, 1, 0, 1, 0);
    tick_n(5);    push_exp("tick_pending", 8'h58, 8'h00, 1, 0, 1, 1);
    press(B_SS);  push_exp("ss_beats_tick", 8'h58, 8'h00, 0, 0, 1, 0);

    // asynchronous reset mid-run, then START held through reset release
    ss = 1'b1; tick_n(1); ss = 1'b0;
    tick_n(3); push_exp("mid_run", 8'h58, 8'h00, 1, 0, 1, 0);
    tick_n(1);
    rst = 1'b1;
    push_exp("rst_async", 8'h00, 8'h00, 0, 0, 1, 0);
    mode = 1'b1; ss = 1'b1;
    tick_n(2);
    rst = 1'b0;
    tick_n(3); push_exp("held_ss", 8'h00, 8'h00, 0, 0, 1, 0);
    ss = 1'b0; tick_n(1);
    press(B_SS); push_exp("up_from_zero", 8'h00, 8'h00, 1, 0, 1, 0);

    tick_n(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Single-clock, parametrised mm:ss timer core for the UP2 board. It replaces the rippled-clock counter chain with a synchronous BCD datapath driven by a clock-enable prescaler. It adds a configurable number of minute digits, a count-up (stopwatch) mode, saturating edits, and an internal end-of-count blink generator. It sits between the button debouncers and the `bcd_to_7seg` decoders in the top level.

## Interface
- `CLK_DIV`, 25_000_000: MCLK cycles per timer second; must be ≥ 2.
- `BLINK_DIV`, 12_500_000: MCLK cycles per BLINK half-period; must be ≥ 1.
- `MIN_DIGITS`, 2: number of BCD minute digits; legal values are 1 to 4.
- `MCLK` in 1: the single clock; all logic runs on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `START_STOP` in 1: debounced, active-high level; acts on its rising edge.
- `CLEAR` in 1: debounced level; acts on its rising edge.
- `ADD_SEC` in 1: debounced level; acts on its rising edge.
- `ADD_MIN` in 1: debounced level; acts on its rising edge.
- `MODE` in 1: 0 selects countdown, 1 selects count-up; sampled only when a start is accepted.
- `SEC_BCD` out 8: seconds as `{tens[3:0], units[3:0]}`; tens is always ≤ 5.
- `MIN_BCD` out 4*MIN_DIGITS: minute digits, with the most significant digit in the top nibble.
- `RUNNING` out 1: high while in the RUN state.
- `ENDED` out 1: high while in the DONE state.
- `BLINK` out 1: display enable; the top level ANDs it with the segment outputs.
- `TICK` out 1: one-cycle pulse on each counted second.

## Operation
- **Edge detection:** each button input has a previous-value register. A button edge is `in & ~prev`. The previous-value registers reset to 1, so a button held through reset does not fire.
- **States:** IDLE, RUN and DONE.
- **IDLE:** edits are allowed.
  - CLEAR sets every digit to 0.
  - ADD_MIN adds 1 to the minute field. If the minutes are already all 9s, the value is unchanged (saturate).
  - ADD_SEC adds 1 to the seconds. 59 wraps to 00 with a carry into the minutes. At max (all 9s:59) the value is unchanged.
  - START_STOP latches MODE into `mode_r` and goes to RUN. Exception: in countdown mode with a value of 00:00, the start is ignored and the state stays IDLE.
- **RUN:**
  - On each prescaler tick, countdown mode decrements the value with BCD borrow (00 seconds becomes 59 with a borrow from the minutes). Count-up mode increments with carry.
  - Countdown: the tick that produces 00:00 also moves the state to DONE.
  - Count-up: a tick taken at max moves the state to DONE and leaves the value at max.
  - START_STOP pauses: the state returns to IDLE and the value is held.
  - CLEAR, ADD_SEC, ADD_MIN and MODE are ignored.
- **DONE:**
  - START_STOP or CLEAR returns the state to IDLE. CLEAR also zeroes the value; START_STOP keeps it.
  - ADD_SEC and ADD_MIN are ignored.
- **Same-cycle priority:**
  - In IDLE: CLEAR beats START_STOP beats ADD_MIN beats ADD_SEC. Only the highest-priority edge acts; the others are dropped.
  - In RUN: a START_STOP edge coinciding with a tick wins, so the tick is discarded and the value is unchanged.
- **Prescaler:** counts 0 to CLK_DIV-1 while in RUN. It is forced to 0 in IDLE and DONE, so after each accepted start it restarts at 0. TICK is asserted when the prescaler equals CLK_DIV-1 in RUN.
- **Blink:** in DONE, BLINK starts at 1 and toggles every BLINK_DIV cycles. In IDLE and RUN, BLINK is 1 and the blink counter is held at 0.
- **Arithmetic rules:**
  - Digits never leave 0–9, and seconds tens never leaves 0–5.
  - Minute overflow in count-up mode is handled as described under RUN, never by wrapping.
  - There is no borrow below 00:00.

## Timing
- **Reset values:** all digits 0, state IDLE, RUNNING=0, ENDED=0, BLINK=1, TICK=0, prescaler 0, blink counter 0.
- **Button latency:** the state and value update at the first MCLK edge that samples the input high. Outputs are registered, so the update is visible one cycle after that edge.
- **First tick:** the first TICK comes CLK_DIV cycles after the edge that entered RUN. Later ticks follow every CLK_DIV cycles. The value changes on the same edge that TICK is sampled high.
- **DONE entry:** ENDED rises on the same edge that the last decrement (or the overflow attempt) is applied.
- **Reset mid-run:** asserting RST during operation immediately returns the block to all reset values.

## Test plan
Simulate with CLK_DIV=10, BLINK_DIV=4, MIN_DIGITS=2.
- **Countdown:** reset; 2 ADD_SEC edges; START with MODE=0 → after 10 cycles value 00:01, after 20 cycles 00:00 with ENDED=1 on the same edge; BLINK then follows the pattern 1,1,1,1,0,0,0,0.
- **Carry and saturation:** ADD_SEC 60 times → 01:00. Preset 99:59, then ADD_SEC → 99:59 (unchanged); ADD_MIN at 99:xx → unchanged.
- **Pause and resume:** 01:00, START, wait 25 cycles (value 00:58), START → IDLE holds 00:58. ADD_SEC is now accepted → 00:59. START again → the next decrement comes exactly 10 cycles later.
- **Count-up overflow and zero start:** 99:58 with MODE=1 → after 2 ticks DONE at 99:59. At 00:00 with MODE=0, START → state stays IDLE and RUNNING=0.
- **Priority and guards:** CLEAR and START edges in the same cycle in IDLE → 00:00 and IDLE. ADD_SEC during RUN → ignored. START coinciding with a tick → value unchanged.
- **Reset and held buttons:** RST asserted mid-RUN → all outputs return to reset values immediately. START held high through reset release → no start.
